pipe_fetch_queue: RTL

Instruction-fetch front end that drives the instruction-memory port and feeds the ID stage. It holds the fetch PC and issues pipelined requests on a valid/ready port, with up to DEPTH requests in flight. In-order responses are buffered with their PCs in a small queue. The head of the queue is presented to ID with valid/ready flow control, and a branch/jump redirect flushes the block in one cycle.

---
 rtl/pipe_fetch_queue_pkg.sv | 12 +
 rtl/pipe_fetch_queue_entry_ram.sv | 32 +++
 rtl/pipe_fetch_queue.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/pipe_fetch_queue_pkg.sv
// Shared CPU-side constants and helpers for the instruction-fetch front end.
package pipe_fetch_queue_pkg;

  localparam int          INST_W   = 32;
  localparam logic [31:0] NOP_INST = 32'h0000_0000;
  localparam logic [31:0] PC_STEP  = 32'd4;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/pipe_fetch_queue_entry_ram.sv
// Per-entry PC/instruction storage for the fetch queue: allocate-time PC write,
// response-time instruction write, asynchronous read of the head entry.
module fetch_entry_ram
  import pipe_fetch_queue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     alloc_we_i,
  input  logic [$clog2(DEPTH)-1:0] alloc_addr_i,
  input  logic [31:0]              alloc_pc_i,
  input  logic                     fill_we_i,
  input  logic [$clog2(DEPTH)-1:0] fill_addr_i,
  input  logic [INST_W-1:0]        fill_inst_i,
  input  logic [$clog2(DEPTH)-1:0] rd_addr_i,
  output logic [31:0]              rd_pc_o,
  output logic [INST_W-1:0]        rd_inst_o
);

  logic [31:0]       pc_q   [DEPTH];
  logic [INST_W-1:0] inst_q [DEPTH];

  // Validity lives in the controller's flags, so the array needs no reset.
  always_ff @(posedge clk) begin
    if (alloc_we_i) pc_q[alloc_addr_i] <= alloc_pc_i;
    if (fill_we_i)  inst_q[fill_addr_i] <= fill_inst_i;
  end

  assign rd_pc_o   = pc_q[rd_addr_i];
  assign rd_inst_o = inst_q[rd_addr_i];

endmodule

// File: rtl/pipe_fetch_queue.sv
// Instruction-fetch front end: pipelined imem requests, in-order response queue
// presented to ID, one-cycle flush on redirect with stale-response dropping.
module pipe_fetch_queue
  import pipe_fetch_queue_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              clrn,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [31:0]       imem_req_addr,
  input  logic              imem_rsp_valid,
  input  logic [INST_W-1:0] imem_rsp_data,
  input  logic              redirect,
  input  logic [31:0]       redirect_pc,
  input  logic              id_ready,
  output logic              if_valid,
  output logic [INST_W-1:0] if_inst,
  output logic [31:0]       if_pc,
  output logic [31:0]       if_pc4
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

  typedef logic [AW-1:0] ptr_t;
  typedef logic [CW-1:0] cnt_t;

  logic             run_q;
  logic [31:0]      pc_q, pc_d;
  logic [DEPTH-1:0] alloc_q, alloc_d;
  logic [DEPTH-1:0] filled_q, filled_d;
  ptr_t             alloc_ptr_q, alloc_ptr_d;
  ptr_t             fill_ptr_q, fill_ptr_d;
  ptr_t             head_ptr_q, head_ptr_d;
  cnt_t             occ_q, occ_d;
  cnt_t             pend_q, pend_d;
  cnt_t             drop_q, drop_d;

  logic              req_fire, rsp_fill, rsp_drop, consume, head_vld;
  logic [CW:0]       inflight;
  logic [31:0]       head_pc;
  logic [INST_W-1:0] head_inst;

  // Handshakes: a transfer happens on a cycle where valid && ready are both high
  // at the rising edge. imem_req_valid depends only on registered state, clrn and
  // redirect (never on imem_req_ready), and drops only when redirect is high.
  assign inflight       = {1'b0, occ_q} + {1'b0, drop_q};
  assign imem_req_valid = clrn && run_q && !redirect && (inflight < DEPTH_W);
  assign imem_req_addr  = pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign rsp_drop = imem_rsp_valid && (drop_q != '0);
  assign rsp_fill = imem_rsp_valid && (drop_q == '0);

  assign head_vld = alloc_q[head_ptr_q] && filled_q[head_ptr_q];
  assign if_valid = clrn && head_vld;
  assign consume  = if_valid && id_ready && !redirect;

  assign if_inst = if_valid ? head_inst : NOP_INST;
  assign if_pc   = if_valid ? head_pc : 32'h0;
  assign if_pc4  = if_pc + PC_STEP;

  always_comb begin
    pc_d        = pc_q;
    alloc_d     = alloc_q;
    filled_d    = filled_q;
    alloc_ptr_d = alloc_ptr_q;
    fill_ptr_d  = fill_ptr_q;
    head_ptr_d  = head_ptr_q;
    occ_d       = occ_q;
    pend_d      = pend_q;
    drop_d      = drop_q;

    if (redirect) begin
      // Every still-unanswered request becomes a response to throw away;
      // a response landing in this very cycle already pays one of them off.
      pc_d        = word_align(redirect_pc);
      alloc_d     = '0;
      filled_d    = '0;
      alloc_ptr_d = '0;
      fill_ptr_d  = '0;
      head_ptr_d  = '0;
      occ_d       = '0;
      pend_d      = '0;
      drop_d      = drop_q + pend_q - cnt_t'(imem_rsp_valid);
    end else begin
      if (req_fire) begin
        alloc_d[alloc_ptr_q]  = 1'b1;
        filled_d[alloc_ptr_q] = 1'b0;
        alloc_ptr_d           = alloc_ptr_q + ptr_t'(1);
        pc_d                  = pc_q + PC_STEP;
      end
      if (rsp_drop) drop_d = drop_q - cnt_t'(1);
      if (rsp_fill) begin
        filled_d[fill_ptr_q] = 1'b1;
        fill_ptr_d           = fill_ptr_q + ptr_t'(1);
      end
      if (consume) begin
        alloc_d[head_ptr_q]  = 1'b0;
        filled_d[head_ptr_q] = 1'b0;
        head_ptr_d           = head_ptr_q + ptr_t'(1);
      end
      occ_d  = occ_q + cnt_t'(req_fire) - cnt_t'(consume);
      pend_d = pend_q + cnt_t'(req_fire) - cnt_t'(rsp_fill);
    end
  end

  // run_q holds requests off for the first cycle after reset is released.
  always_ff @(posedge clk) begin
    if (!clrn) begin
      run_q       <= 1'b0;
      pc_q        <= RESET_PC;
      alloc_q     <= '0;
      filled_q    <= '0;
      alloc_ptr_q <= '0;
      fill_ptr_q  <= '0;
      head_ptr_q  <= '0;
      occ_q       <= '0;
      pend_q      <= '0;
      drop_q      <= '0;
    end else begin
      run_q       <= 1'b1;
      pc_q        <= pc_d;
      alloc_q     <= alloc_d;
      filled_q    <= filled_d;
      alloc_ptr_q <= alloc_ptr_d;
      fill_ptr_q  <= fill_ptr_d;
      head_ptr_q  <= head_ptr_d;
      occ_q       <= occ_d;
      pend_q      <= pend_d;
      drop_q      <= drop_d;
    end
  end

  fetch_entry_ram #(.DEPTH(DEPTH)) u_ram (
    .clk          (clk),
    .alloc_we_i   (req_fire),
    .alloc_addr_i (alloc_ptr_q),
    .alloc_pc_i   (pc_q),
    .fill_we_i    (rsp_fill && !redirect),
    .fill_addr_i  (fill_ptr_q),
    .fill_inst_i  (imem_rsp_data),
    .rd_addr_i    (head_ptr_q),
    .rd_pc_o      (head_pc),
    .rd_inst_o    (head_inst)
  );

endmodule
